// File: rtl/neopixel_strand_driver_if.sv
// Host-side load/go bus of neopixel_strand_driver.
// NUM_NPX sizes the pixel index. The host drives the master modport and the driver takes the slave modport.
interface neopixel_strand_driver_if #(
    parameter int NUM_NPX = 17
);
    logic [7:0]                 red;
    logic [7:0]                 green;
    logic [7:0]                 blue;
    logic [$clog2(NUM_NPX)-1:0] pixel;
    logic                       load;
    logic                       go;
    logic [7:0]                 brightness;
    logic                       ready;
    logic                       frame_done;

    modport master (
        output red, green, blue, pixel, load, go, brightness,
        input  ready, frame_done
    );

    modport slave (
        input  red, green, blue, pixel, load, go, brightness,
        output ready, frame_done
    );
endinterface

// File: rtl/neopixel_strand_driver.sv
// WS2812 strand driver: per-pixel GRB storage, parametrised bit timing, one-cycle frame_done pulse.
// Optional global brightness scaling is enabled by defining NPX_BRIGHTNESS_EN.
module neopixel_strand_driver #(
    parameter int NUM_NPX = 17,
    parameter int T0H     = 18,
    parameter int T0L     = 40,
    parameter int T1H     = 35,
    parameter int T1L     = 30,
    parameter int TRST    = 2500
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    neopixel_strand_driver_if.slave        bus,
    output logic                           neopixel_data
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PW         = $clog2(NUM_NPX);
    localparam int FRAME_BITS = NUM_NPX * 24;
    localparam int BCW        = $clog2(FRAME_BITS + 1);
    localparam int MAX_T      = max2(max2(max2(T0H, T0L), max2(T1H, T1L)), TRST);
    localparam int CW         = $clog2(MAX_T + 1);

    localparam logic [CW-1:0]  T0H_END   = CW'(T0H - 1);
    localparam logic [CW-1:0]  T0L_END   = CW'(T0L - 1);
    localparam logic [CW-1:0]  T1H_END   = CW'(T1H - 1);
    localparam logic [CW-1:0]  T1L_END   = CW'(T1L - 1);
    localparam logic [CW-1:0]  TRST_END  = CW'(TRST - 1);
    localparam logic [PW:0]    PIX_LIMIT = (PW + 1)'(NUM_NPX);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_FETCH,
        S_SEND_FETCH,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [23:0]     r_mem [NUM_NPX];
    logic [23:0]     r_shift;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_word_bit;
    logic [BCW-1:0]  r_bit_cnt;
    logic [PW-1:0]   r_pix;
    logic            r_data;
    logic            r_frame_done;

    logic            w_write;
    logic            w_fetch;
    logic            w_done;
    logic            w_high_end;
    logic            w_low_end;
    logic            w_gap_end;
    logic            w_word_last;
    logic            w_frame_last;
    logic [23:0]     w_raw;
    logic [23:0]     w_word;

    assign w_write      = (r_state == S_IDLE) && bus.load && ({1'b0, bus.pixel} < PIX_LIMIT);
    assign w_high_end   = (r_cnt == (r_shift[23] ? T1H_END : T0H_END));
    assign w_low_end    = (r_cnt == (r_shift[23] ? T1L_END : T0L_END));
    assign w_gap_end    = (r_cnt == TRST_END);
    assign w_word_last  = (r_word_bit == 5'd23);
    assign w_frame_last = (r_bit_cnt == LAST_BIT);
    assign w_raw        = r_mem[r_pix];

`ifdef NPX_BRIGHTNESS_EN
    logic [7:0] r_bright;
    logic [7:0] w_scale;
    logic [8:0] w_mult;

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] m);
        return 8'(({8'd0, c} * {7'd0, m}) >> 8);
    endfunction

    // Pixel 0 uses the live input so the value sampled for the frame is also the one applied to it.
    assign w_scale = (r_pix == '0) ? bus.brightness : r_bright;
    assign w_mult  = {1'b0, w_scale} + 9'd1;
    assign w_word  = {scale_ch(w_raw[23:16], w_mult),
                      scale_ch(w_raw[15:8],  w_mult),
                      scale_ch(w_raw[7:0],   w_mult)};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_bright <= '0;
        end else if (w_fetch && (r_pix == '0)) begin
            r_bright <= bus.brightness;
        end
    end
`else
    logic [7:0] w_unused_bright;

    assign w_unused_bright = bus.brightness;
    assign w_word          = w_raw;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_fetch      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_CLEAR: w_state_next = S_SEND_FETCH;
            S_IDLE: begin
                if (bus.go) w_state_next = S_FETCH;
            end
            S_FETCH, S_SEND_FETCH: begin
                w_fetch      = 1'b1;
                w_state_next = S_HIGH;
            end
            S_HIGH: begin
                if (w_high_end) w_state_next = S_LOW;
            end
            S_LOW: begin
                if (w_low_end) begin
                    if (w_frame_last)     w_state_next = S_GAP;
                    else if (w_word_last) w_state_next = S_FETCH;
                    else                  w_state_next = S_HIGH;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = S_CLEAR;
        endcase
    end

    // NOTE: storage must read back as zero after reset, so it gets an explicit clear loop instead of
    // being left uninitialised like a RAM. The clear runs in CLEAR too, so a mid-frame reset also wipes it.
    always_ff @(posedge CLOCK_50) begin
        if (reset || (r_state == S_CLEAR)) begin
            for (int i = 0; i < NUM_NPX; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[bus.pixel] <= {bus.green, bus.red, bus.blue};
        end
    end

    // NOTE: sequential state uses only non-blocking assignments, so every register sees pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_word_bit   <= '0;
            r_bit_cnt    <= '0;
            r_pix        <= '0;
            r_data       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_data       <= (w_state_next == S_HIGH);
            r_frame_done <= w_done;
            if (w_fetch) begin
                r_shift    <= w_word;
                r_cnt      <= '0;
                r_word_bit <= '0;
            end else begin
                case (r_state)
                    S_HIGH: r_cnt <= w_high_end ? '0 : r_cnt + 1'b1;
                    S_LOW: begin
                        if (w_low_end) begin
                            r_cnt      <= '0;
                            r_shift    <= {r_shift[22:0], 1'b0};
                            r_word_bit <= r_word_bit + 1'b1;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (w_word_last && !w_frame_last) r_pix <= r_pix + 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_GAP: r_cnt <= r_cnt + 1'b1;
                    default: begin
                        r_cnt      <= '0;
                        r_word_bit <= '0;
                        r_bit_cnt  <= '0;
                        r_pix      <= '0;
                    end
                endcase
            end
        end
    end

    assign neopixel_data  = r_data;
    assign bus.ready      = (r_state == S_IDLE);
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_neopixel_strand_driver.sv
// Self-checking bench for neopixel_strand_driver: each expected frame waveform is built from the stored-colour
// model and the bit-timing rules, then compared cycle by cycle and decoded back into pixel words.
module tb_neopixel_strand_driver;
    localparam int NUM_NPX = 3;
    localparam int T0H     = 18;
    localparam int T0L     = 40;
    localparam int T1H     = 35;
    localparam int T1L     = 30;
    localparam int TRST    = 2500;
    localparam int PW      = $clog2(NUM_NPX);

    logic        CLOCK_50;
    logic        reset;
    logic        neopixel_data;
    int          n_checks;
    int          n_errors;
    logic [23:0] model_mem [NUM_NPX];
    logic [7:0]  bright;

    neopixel_strand_driver_if #(.NUM_NPX(NUM_NPX)) bus ();

    neopixel_strand_driver #(
        .NUM_NPX(NUM_NPX),
        .T0H    (T0H),
        .T0L    (T0L),
        .T1H    (T1H),
        .T1L    (T1L),
        .TRST   (TRST)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .bus          (bus),
        .neopixel_data(neopixel_data)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

`ifdef NPX_BRIGHTNESS_EN
    function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
        int s;
        s = int'(b) + 1;
        return {8'(int'(w[23:16]) * s / 256), 8'(int'(w[15:8]) * s / 256), 8'(int'(w[7:0]) * s / 256)};
    endfunction
`endif

    task automatic drive_px(input int pix, input logic [23:0] grb);
        bus.pixel = PW'(pix);
        bus.green = grb[23:16];
        bus.red   = grb[15:8];
        bus.blue  = grb[7:0];
        bus.load  = 1'b1;
    endtask

    // Called only while the driver is known to be idle.
    task automatic load_idle(input int pix, input logic [23:0] grb);
        drive_px(pix, grb);
        if (pix < NUM_NPX) model_mem[pix] = grb;
        step();
        bus.load = 1'b0;
    endtask

    // Starts right after the fetch cycle; the next edge must begin the first high phase.
    task automatic capture_frame(input string tag, input int disturb_at);
        logic [23:0] exp_w [NUM_NPX];
        logic        exp_q [$];
        logic [23:0] got_w;
        logic        v;
        logic        prev;
        int          mism;
        int          hi_len;
        int          nbits;
        for (int p = 0; p < NUM_NPX; p++) begin
`ifdef NPX_BRIGHTNESS_EN
            exp_w[p] = scale_word(model_mem[p], bright);
`else
            exp_w[p] = model_mem[p];
`endif
            for (int b = 23; b >= 0; b--) begin
                v = exp_w[p][b];
                repeat (v ? T1H : T0H) exp_q.push_back(1'b1);
                repeat (v ? T1L : T0L) exp_q.push_back(1'b0);
            end
            if (p != NUM_NPX - 1) exp_q.push_back(1'b0);
        end
        repeat (TRST) exp_q.push_back(1'b0);

        mism   = 0;
        hi_len = 0;
        nbits  = 0;
        got_w  = '0;
        prev   = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            if (neopixel_data !== exp_q[i] || bus.ready !== 1'b0 || bus.frame_done !== 1'b0) mism++;
            if (neopixel_data === 1'b1) begin
                hi_len++;
            end else if (prev === 1'b1) begin
                got_w  = {got_w[22:0], (hi_len == T1H)};
                hi_len = 0;
                nbits++;
                if ((nbits % 24 == 0) && (nbits <= NUM_NPX * 24))
                    check($sformatf("%s_px%0d", tag, nbits / 24 - 1), got_w, exp_w[nbits / 24 - 1]);
            end
            prev = neopixel_data;
            if (i == disturb_at) begin
                drive_px(0, 24'hFFFFFF);
                bus.go = 1'b1;
            end else if (i == disturb_at + 1) begin
                bus.load = 1'b0;
                bus.go   = 1'b0;
            end
        end
        check({tag, "_wave_mism"}, mism, 0);
        check({tag, "_nbits"}, nbits, NUM_NPX * 24);
        step();
        check({tag, "_done"}, bus.frame_done, 1);
        check({tag, "_ready"}, bus.ready, 1);
    endtask

    task automatic idle_check(input string tag);
        step();
        check({tag, "_done_low"}, bus.frame_done, 0);
        check({tag, "_idle"}, bus.ready, 1);
    endtask

    task automatic start_frame(input string tag, input logic do_load, input int pix,
                               input logic [23:0] grb, input int disturb_at);
        bus.brightness = bright;
        bus.go         = 1'b1;
        if (do_load) begin
            drive_px(pix, grb);
            if (pix < NUM_NPX) model_mem[pix] = grb;
        end
        step();
        bus.go   = 1'b0;
        bus.load = 1'b0;
        check({tag, "_fetch_ready"}, bus.ready, 0);
        check({tag, "_fetch_data"}, neopixel_data, 0);
        capture_frame(tag, disturb_at);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        bright         = 8'hFF;
        bus.load       = 1'b0;
        bus.go         = 1'b0;
        bus.red        = '0;
        bus.green      = '0;
        bus.blue       = '0;
        bus.pixel      = '0;
        bus.brightness = bright;
        for (int p = 0; p < NUM_NPX; p++) model_mem[p] = '0;

        repeat (3) step();
        check("rst_data", neopixel_data, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_done", bus.frame_done, 0);
        reset = 1'b0;
        step();
        check("boot_clear_ready", bus.ready, 0);
        capture_frame("boot", -1);
        idle_check("boot");

        load_idle(1, 24'h800001);
        start_frame("pattern", 1'b0, 0, 24'h0, -1);
        idle_check("pattern");

        bright = 8'd127;
        start_frame("load_go", 1'b1, 0, 24'hFF0000, -1);
        idle_check("load_go");

        bright = 8'hFF;
        load_idle(0, 24'h000000);
        start_frame("busy_load", 1'b0, 0, 24'h0, 700);
        idle_check("busy_noqueue");

        load_idle(NUM_NPX, 24'hFFFFFF);
        start_frame("out_of_range", 1'b0, 0, 24'h0, -1);
        idle_check("out_of_range");

        for (int f = 0; f < 2; f++) begin
            bright = (f == 0) ? 8'h00 : 8'($urandom);
            repeat (3) load_idle(int'($urandom_range(0, NUM_NPX)), 24'($urandom));
            start_frame($sformatf("rnd%0d", f), 1'b1, int'($urandom_range(0, NUM_NPX - 1)),
                        24'($urandom), -1);
            idle_check($sformatf("rnd%0d", f));
        end

        bright         = 8'hFF;
        bus.brightness = bright;
        load_idle(0, 24'hFFFFFF);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        repeat (10) step();
        check("midrst_high", neopixel_data, 1);
        reset = 1'b1;
        step();
        check("midrst_data", neopixel_data, 0);
        check("midrst_ready", bus.ready, 0);
        reset = 1'b0;
        for (int p = 0; p < NUM_NPX; p++) model_mem[p] = '0;
        step();
        check("midrst_clear_ready", bus.ready, 0);
        capture_frame("midrst", -1);
        idle_check("midrst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/neopixel_strand_driver.md
# neopixel_strand_driver

Parametrised NeoPixel (WS2812) strand driver, the next generation of the fixed 17-pixel controller. It has these capabilities:
- pixel count and all bit-timing intervals set by parameters;
- per-pixel colour storage written one pixel at a time;
- optional global brightness scaling;
- a one-cycle frame-complete pulse.

It sits between game/display logic and the single-wire strand output pin.

## Interface
Parameters:
- NUM_NPX, 17, pixels on the strand; must be ≥ 2
- T0H, 18, cycles high for a 0 bit
- T0L, 40, cycles low for a 0 bit
- T1H, 35, cycles high for a 1 bit
- T1L, 30, cycles low for a 1 bit
- TRST, 2500, cycles low for the latch/reset gap after a frame

Ports (one clock; reset is synchronous and active-high):
- CLOCK_50  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- red, green, blue  in  8 each  colour for the pixel being loaded
- pixel  in  $clog2(NUM_NPX)  index of the pixel to load
- load  in  1  write {green,red,blue} into pixel slot
- go  in  1  request transmission of a frame
- brightness  in  8  global scale, used only with NPX_BRIGHTNESS_EN
- neopixel_data  out  1  strand serial data
- ready  out  1  high when idle and accepting load/go
- frame_done  out  1  one-cycle pulse at the end of every frame

## Operation
- Storage: NUM_NPX × 24-bit words, each {G[7:0],R[7:0],B[7:0]}.
- Load rules:
  - load is honoured only while ready=1.
  - load with pixel ≥ NUM_NPX is ignored.
  - load while busy is ignored; stored words are unchanged.
- Serial order: pixel 0 first; within each word G, R, B, MSB first; NUM_NPX*24 bits per frame.
- Bit encoding:
  - bit 1: high T1H cycles, then low T1L cycles.
  - bit 0: high T0H cycles, then low T0L cycles.
  - After the last bit, low for TRST cycles.
- FSM states:
  - CLEAR: one cycle; zeroes all storage; next SEND_FETCH.
  - IDLE: ready=1; go → FETCH.
  - FETCH: loads the current pixel word (scaled if enabled) into a 24-bit shifter; → HIGH.
  - HIGH: data=1 for THx cycles; → LOW.
  - LOW: data=0 for TxL cycles. Then:
    - more bits in the word → HIGH;
    - word done and more pixels → FETCH;
    - last bit of the frame → GAP.
  - GAP: data=0 for TRST cycles; → IDLE and pulse frame_done.
  - SEND_FETCH: same as FETCH; used only for the post-reset frame.
- Reset / startup: reset forces CLEAR. An all-zero frame is then sent automatically, and ready stays low until it completes.
- Simultaneous load and go in IDLE: the write lands first, and the frame carries the new value.
- go while busy is ignored. It is not queued.
- Reset mid-frame: neopixel_data drops to 0 on the next edge. Storage is cleared and a fresh all-zero frame is sent; there is no partial resume.
- Arithmetic: counters are sized $clog2(max interval + 1). The bit counter is sized $clog2(NUM_NPX*24 + 1). There is no wrap within a frame.

## Timing
- Reset values: neopixel_data=0, ready=0, frame_done=0, all storage 0.
- go sampled at edge k in IDLE:
  - ready falls after edge k.
  - neopixel_data rises after edge k+1, since FETCH takes one cycle.
- Each bit lasts exactly THx + TxL cycles. A pixel boundary adds one FETCH cycle, held low and appended to the preceding low phase.
- Frame length: 1 + Σ(bit cycles) + (NUM_NPX−1) + TRST cycles.
- ready rises in the same cycle that frame_done pulses.
- load/go are single-cycle strobes; holding go high in IDLE starts back-to-back frames.

## Configuration
- NPX_BRIGHTNESS_EN defined:
  - brightness is sampled at the FETCH of pixel 0 and held for the frame.
  - Each channel is sent as (c × (brightness+1)) >> 8.
  - 255 gives identity; 0 gives all-zero output.
  - Stored values are never modified.
- Not defined: the brightness port is unused and raw stored bytes are sent.

## Test plan
- Reset with NUM_NPX=17:
  - neopixel_data stays 0 and ready stays 0 through an all-zero frame of 408 bits, each 18 high / 40 low.
  - Then 2500 low cycles.
  - Then frame_done pulses once and ready=1.
- NUM_NPX=2; load pixel 1 = R 0x00, G 0x80, B 0x01, then go:
  - first 24 bits are 0, at 18/40 cycles each;
  - pixel 1 sends bit pattern 1, then 22 zeros, then 1; a 1 bit is 35 high / 30 low.
- Load pixel 0 and go on the same edge with G=0xFF: the first 8 bits of that frame are 1s.
- With ready=0, pulse load with pixel 0 = 0xFFFFFF: the next frame still sends pixel 0 as zero.
- NUM_NPX=17 with load pixel=20: no stored word changes, and the next frame is identical to the previous one.
- NPX_BRIGHTNESS_EN defined:
  - brightness=127, G=0xFF: sends 0x7F.
  - brightness=0: whole frame is zero.
- Reset asserted mid-bit:
  - neopixel_data=0 next cycle;
  - a full zero frame follows, then ready=1.
